lzc_iter: RTL and testbench



---
 rtl/lzc_iter.sv | 93 +++++++++
 tb/tb_lzc_iter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lzc_iter.sv
// Iterative leading-zero counter: one CHUNK-bit leading-zero stage is reused
// across the word from the MSB down, and the scan stops at the first non-zero chunk.
module lzc_iter #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ZW  = $clog2(CHUNK+1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_flag;

  logic [CHUNK-1:0] w_top;
  logic [ZW-1:0]    w_z;
  logic             w_nz, w_last;

  assign w_top  = r_shreg[WIDTH-1 -: CHUNK];
  assign w_nz   = |w_top;
  assign w_last = (r_idx == IW'(NCH-1));

  // Highest set bit wins: later iterations overwrite lower ones.
  always_comb begin
    w_z = ZW'(CHUNK);
    for (int i = 0; i < CHUNK; i++)
      if (w_top[i]) w_z = ZW'(CHUNK-1-i);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)           w_next = S_SCAN;
      S_SCAN: if (w_nz || w_last)     w_next = S_DONE;
      S_DONE: if (out_ready)          w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_shreg <= in_data;
          r_acc   <= '0;
          r_idx   <= '0;
          r_flag  <= 1'b0;
        end
        S_SCAN: begin
          if (w_nz) begin
            r_acc <= r_acc + CW'(w_z);
          end else if (!w_last) begin
            r_acc   <= r_acc + CW'(CHUNK);
            r_shreg <= r_shreg << CHUNK;
            r_idx   <= r_idx + 1'b1;
          end else begin
            r_acc  <= CW'(WIDTH);
            r_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is masked by reset so a word offered during reset is never taken.
  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign out_count = r_acc;
  assign out_zero  = r_flag;
endmodule

// File: tb/tb_lzc_iter.sv
// Bench for lzc_iter at CHUNK = 8, 2 and 32: directed cases on the CHUNK=8
// instance, then random words with stalls on all three against a reference count.
module tb_lzc_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_lz(input logic [31:0] x);
    for (int i = 31; i >= 0; i--)
      if (x[i]) return 31 - i;
    return 32;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int CH = (k == 0) ? 8 : ((k == 1) ? 2 : 32);
    logic        iv = 1'b0, orr = 1'b0, fin = 1'b0;
    logic [31:0] id = '0;
    logic        ir, ov, z;
    logic [5:0]  cnt;

    lzc_iter #(.WIDTH(32), .CHUNK(CH)) dut (
      .clk(clk), .reset(rst),
      .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(orr), .out_count(cnt), .out_zero(z)
    );

    // Offer d, measure cycles from accept to out_valid, hold out_ready low
    // for `stall` cycles, then take the result and check the handshake.
    task automatic run_word(input logic [31:0] d, input int stall,
                            output int lat, output logic [5:0] c, output logic zf);
      int guard = 0;
      iv = 1'b1; id = d;
      while (!ir && guard < 100) begin @(negedge clk); guard++; end
      chk($sformatf("c%0d accept_seen", CH), ir, 1);
      @(posedge clk); @(negedge clk);
      iv = 1'b0; id = $urandom;
      lat = 0;
      while (!ov && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
      c = cnt; zf = z;
      chk($sformatf("c%0d ov_rise", CH), ov, 1);
      repeat (stall) begin
        @(posedge clk); @(negedge clk);
        chk($sformatf("c%0d hold_cnt", CH), cnt, c);
        chk($sformatf("c%0d hold_ov", CH), ov, 1);
        chk($sformatf("c%0d hold_ir", CH), ir, 0);
      end
      orr = 1'b1;
      @(posedge clk); @(negedge clk);
      orr = 1'b0;
      chk($sformatf("c%0d ov_fall", CH), ov, 0);
      chk($sformatf("c%0d ir_rise", CH), ir, 1);
    endtask

    task automatic directed(input logic [31:0] d, input int stall,
                            input int e_cnt, input int e_lat);
      int lat; logic [5:0] c; logic zf;
      run_word(d, stall, lat, c, zf);
      chk($sformatf("dir %h count", d), c, e_cnt);
      chk($sformatf("dir %h zero", d), zf, (e_cnt == 32) ? 1 : 0);
      chk($sformatf("dir %h latency", d), lat, e_lat);
    endtask

    initial begin
      int lat, lz, ek;
      logic [5:0] c; logic zf;
      logic [31:0] d;
      if (k == 0) begin
        // Reset state, with a word offered during reset that must be ignored.
        iv = 1'b1; id = 32'h0000_0001;
        repeat (3) @(negedge clk);
        chk("rst ir_low", ir, 0);
        chk("rst ov", ov, 0);
        chk("rst count", cnt, 0);
        chk("rst zero", z, 0);
        rst = 1'b0; iv = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); chk("rst no_accept", ov, 0); end
        chk("rst ir_high", ir, 1);

        directed(32'h8000_0000, 0, 0, 1);
        directed(32'h0000_0001, 0, 31, 4);
        directed(32'h0000_0000, 0, 32, 4);
        directed(32'h0010_FFFF, 5, 11, 2);

        // Abort: reset lands on the second SCAN decision edge.
        iv = 1'b1; id = 32'h0000_1000;
        @(posedge clk); @(negedge clk);
        iv = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        chk("abort ir_low", ir, 0);
        repeat (2) begin @(posedge clk); @(negedge clk); chk("abort ov", ov, 0); end
        rst = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); chk("abort no_stale", ov, 0); end
        chk("abort count", cnt, 0);
        chk("abort zero", z, 0);
        directed(32'h00F0_0000, 0, 8, 2);
        go = 1'b1;
      end else begin
        wait (go);
        @(negedge clk);
      end

      for (int n = 0; n < 60; n++) begin
        d = $urandom >> $urandom_range(0, 32);
        lz = ref_lz(d);
        ek = (lz == 32) ? 32 / CH : lz / CH + 1;
        run_word(d, $urandom_range(0, 3), lat, c, zf);
        chk($sformatf("c%0d rnd %h count", CH, d), c, lz);
        chk($sformatf("c%0d rnd %h zero", CH, d), zf, (lz == 32) ? 1 : 0);
        chk($sformatf("c%0d rnd %h latency", CH, d), lat, ek);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g[0].fin && g[1].fin && g[2].fin) && t < 50000) begin
      @(posedge clk); t++;
    end
    chk("run_complete", (g[0].fin && g[1].fin && g[2].fin) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
